// File: rtl/dp_feeder.sv
// dp_feeder: reads pixel and weight words from two synchronous RAMs and
// packs them into PARALLEL x BUS_WIDTH slot groups for a dot-product unit.
// Every neuron walks the full pixel vector in groups of G = PARALLEL*BUS_WIDTH.
// Slots past PIXEL_N are padded with zeros and issue no RAM read.
//
// Ports:
//   clk, GlobalReset_n      : clock; asynchronous active-low reset
//   start / busy / done     : run control; done is a single-cycle pulse
//   pix_rd_en/pix_addr      : pixel RAM read port (data returns one cycle later)
//   w_rd_en/w_addr          : weight RAM read port (data returns one cycle later)
//   pix_rdata/w_rdata       : RAM read data
//   Pixels/Weights          : packed slot bus, slot (j,k) at index j*BUS_WIDTH+k
//   bus_valid/bus_ready     : valid/ready handshake for one group
//   bus_last/bus_neuron     : group is the last one of its neuron / neuron index

// One lane of the slot bus: BUS_WIDTH staging slots plus the output register.
module dp_feeder_lane #(
  parameter int LANE        = 0,
  parameter int BUS_WIDTH   = 7,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int SL_W        = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cap_en,
  input  logic [SL_W-1:0]                    cap_slot,
  input  logic                               cap_pad,
  input  logic [PIXEL_SIZE-1:0]              pix_rdata,
  input  logic [WEIGHT_SIZE-1:0]             w_rdata,
  input  logic                               xfer,
  output logic [BUS_WIDTH*PIXEL_SIZE-1:0]    pix_out,
  output logic [BUS_WIDTH*WEIGHT_SIZE-1:0]   w_out
);
  logic [BUS_WIDTH-1:0][PIXEL_SIZE-1:0]  pix_stg, pix_q;
  logic [BUS_WIDTH-1:0][WEIGHT_SIZE-1:0] w_stg, w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_stg <= '0;
      w_stg   <= '0;
      pix_q   <= '0;
      w_q     <= '0;
    end else begin
      for (int k = 0; k < BUS_WIDTH; k++) begin
        // Global slot index of (LANE, k); padded slots load zero.
        if (cap_en && cap_slot == SL_W'(LANE*BUS_WIDTH + k)) begin
          pix_stg[k] <= cap_pad ? '0 : pix_rdata;
          w_stg[k]   <= cap_pad ? '0 : w_rdata;
        end
      end
      if (xfer) begin
        pix_q <= pix_stg;
        w_q   <= w_stg;
      end
    end
  end

  assign pix_out = pix_q;
  assign w_out   = w_q;
endmodule

module dp_feeder #(
  parameter int NEURONS     = 10,
  parameter int PIXEL_N     = 785,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int PARALLEL    = 4,
  parameter int BUS_WIDTH   = 7,
  parameter int PA_W        = 10,
  parameter int WA_W        = 13
) (
  input  logic                                    clk,
  input  logic                                    GlobalReset_n,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    pix_rd_en,
  output logic [PA_W-1:0]                         pix_addr,
  input  logic [PIXEL_SIZE-1:0]                   pix_rdata,
  output logic                                    w_rd_en,
  output logic [WA_W-1:0]                         w_addr,
  input  logic [WEIGHT_SIZE-1:0]                  w_rdata,
  output logic [BUS_WIDTH*PARALLEL*PIXEL_SIZE-1:0]  Pixels,
  output logic [BUS_WIDTH*PARALLEL*WEIGHT_SIZE-1:0] Weights,
  output logic                                    bus_valid,
  input  logic                                    bus_ready,
  output logic                                    bus_last,
  output logic [3:0]                              bus_neuron
);
  localparam int G    = PARALLEL*BUS_WIDTH;
  localparam int NG   = (PIXEL_N + G - 1) / G;
  localparam int SL_W = $clog2(G + 1);
  localparam int GR_W = $clog2(NG + 1);
  // Index counter must cover both the padded range and the address width.
  localparam int IX_W = ($clog2(NG*G + 1) > PA_W) ? $clog2(NG*G + 1) : PA_W;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  // One-deep read pipeline: the slot issued last cycle and whether it was padded.
  typedef struct packed {
    logic            vld;
    logic            pad;
    logic            last;
    logic [SL_W-1:0] slot;
  } cap_t;

  state_t          state, state_nx;
  cap_t            cap;
  logic [SL_W-1:0] slot;
  logic [GR_W-1:0] grp;
  logic [3:0]      neu;
  logic [IX_W-1:0] pix_idx;
  logic [WA_W-1:0] w_base;
  logic            stg_full, xfer, pad, issue;
  logic            grp_end, last_grp, final_grp, final_acc;

  assign pad       = pix_idx >= IX_W'(PIXEL_N);
  assign grp_end   = slot == SL_W'(G - 1);
  assign last_grp  = grp == GR_W'(NG - 1);
  assign final_grp = last_grp && (neu == 4'(NEURONS - 1));
  assign xfer      = stg_full && (!bus_valid || bus_ready);
  // Only the very last group of the run carries last with the top neuron index.
  assign final_acc = bus_valid && bus_ready && bus_last && (bus_neuron == 4'(NEURONS - 1));

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: begin
        issue = 1'b1;
        busy  = 1'b1;
        if (grp_end) state_nx = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (xfer && !final_grp) state_nx = FETCH;
        else if (final_acc)     state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pix_rd_en = issue && !pad;
  assign w_rd_en   = issue && !pad;
  assign pix_addr  = PA_W'(pix_idx);
  assign w_addr    = w_base + WA_W'(pix_idx);

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state      <= IDLE;
      cap        <= '0;
      slot       <= '0;
      grp        <= '0;
      neu        <= '0;
      pix_idx    <= '0;
      w_base     <= '0;
      stg_full   <= 1'b0;
      bus_valid  <= 1'b0;
      bus_last   <= 1'b0;
      bus_neuron <= '0;
    end else begin
      state    <= state_nx;
      cap.vld  <= issue;
      cap.pad  <= pad;
      cap.last <= grp_end;
      cap.slot <= slot;

      unique case (state)
        IDLE: begin
          slot    <= '0;
          grp     <= '0;
          neu     <= '0;
          pix_idx <= '0;
          w_base  <= '0;
        end
        FETCH: if (!grp_end) begin
          slot    <= slot + 1'b1;
          pix_idx <= pix_idx + 1'b1;
        end
        WAIT: if (xfer && !final_grp) begin
          slot <= '0;
          if (last_grp) begin
            grp     <= '0;
            neu     <= neu + 4'd1;
            pix_idx <= '0;
            w_base  <= w_base + WA_W'(PIXEL_N);
          end else begin
            grp     <= grp + 1'b1;
            pix_idx <= pix_idx + 1'b1;
          end
        end
        default: ;
      endcase

      // Staging is complete once the final slot's data lands.
      if (cap.vld && cap.last) stg_full <= 1'b1;
      else if (xfer)           stg_full <= 1'b0;

      if (xfer) begin
        bus_valid  <= 1'b1;
        bus_last   <= last_grp;
        bus_neuron <= neu;
      end else if (bus_ready) begin
        bus_valid  <= 1'b0;
      end
    end
  end

  for (genvar j = 0; j < PARALLEL; j++) begin : g_lane
    dp_feeder_lane #(
      .LANE(j), .BUS_WIDTH(BUS_WIDTH), .PIXEL_SIZE(PIXEL_SIZE),
      .WEIGHT_SIZE(WEIGHT_SIZE), .SL_W(SL_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (GlobalReset_n),
      .cap_en   (cap.vld),
      .cap_slot (cap.slot),
      .cap_pad  (cap.pad),
      .pix_rdata(pix_rdata),
      .w_rdata  (w_rdata),
      .xfer     (xfer),
      .pix_out  (Pixels[j*BUS_WIDTH*PIXEL_SIZE +: BUS_WIDTH*PIXEL_SIZE]),
      .w_out    (Weights[j*BUS_WIDTH*WEIGHT_SIZE +: BUS_WIDTH*WEIGHT_SIZE])
    );
  end
endmodule

// File: tb/tb_dp_feeder.sv
// Bench for dp_feeder: a default-parameter instance and a small instance
// (PIXEL_N=30, PARALLEL=2, BUS_WIDTH=3, NEURONS=2). Expected groups and
// expected read strobes are queued when a run is started and popped as the
// DUT produces them.
module tb_dp_feeder;
  localparam int DG = 28, DNG = 29, DPN = 785, DNEU = 10;
  localparam int DPX = DG*10, DWX = DG*19;
  localparam int SG = 6, SNG = 5, SPN = 30, SNEU = 2;
  localparam int SPX = SG*10, SWX = SG*19;

  typedef struct {
    logic [DPX-1:0] pix;
    logic [DWX-1:0] w;
    logic           last;
    logic [3:0]     neu;
  } grp_t;
  typedef struct { int pa; int wa; } rd_t;

  grp_t q_grp[$];
  rd_t  q_rd[$];
  int   n_chk = 0, n_fail = 0;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic d_start = 1'b0, d_ready = 1'b1, d_busy, d_done, d_pre, d_wre, d_valid, d_last;
  logic [9:0]  d_pa;  logic [9:0]  d_prd = '0;
  logic [12:0] d_wa;  logic [18:0] d_wrd = '0;
  logic [DPX-1:0] d_pix; logic [DWX-1:0] d_w; logic [3:0] d_neu;

  logic s_start = 1'b0, s_ready = 1'b1, s_busy, s_done, s_pre, s_wre, s_valid, s_last;
  logic [9:0]  s_pa;  logic [9:0]  s_prd = '0;
  logic [12:0] s_wa;  logic [18:0] s_wrd = '0;
  logic [SPX-1:0] s_pix; logic [SWX-1:0] s_w; logic [3:0] s_neu;

  // Synchronous RAMs whose contents are the low bits of the address.
  always @(posedge clk) begin
    if (d_pre) d_prd <= d_pa;
    if (d_wre) d_wrd <= 19'(d_wa);
    if (s_pre) s_prd <= s_pa;
    if (s_wre) s_wrd <= 19'(s_wa);
  end

  dp_feeder u_def (
    .clk(clk), .GlobalReset_n(rst_n), .start(d_start), .busy(d_busy), .done(d_done),
    .pix_rd_en(d_pre), .pix_addr(d_pa), .pix_rdata(d_prd),
    .w_rd_en(d_wre), .w_addr(d_wa), .w_rdata(d_wrd),
    .Pixels(d_pix), .Weights(d_w), .bus_valid(d_valid), .bus_ready(d_ready),
    .bus_last(d_last), .bus_neuron(d_neu)
  );

  dp_feeder #(.NEURONS(SNEU), .PIXEL_N(SPN), .PARALLEL(2), .BUS_WIDTH(3)) u_sml (
    .clk(clk), .GlobalReset_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .pix_rd_en(s_pre), .pix_addr(s_pa), .pix_rdata(s_prd),
    .w_rd_en(s_wre), .w_addr(s_wa), .w_rdata(s_wrd),
    .Pixels(s_pix), .Weights(s_w), .bus_valid(s_valid), .bus_ready(s_ready),
    .bus_last(s_last), .bus_neuron(s_neu)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({d_busy, d_done, d_pre, d_wre, d_valid, d_last, d_neu, d_pa, d_wa} !== '0 ||
        d_pix !== '0 || d_w !== '0) begin
      n_fail++;
      $display("FAIL reset_def: got ctl=%b pix=%h w=%h expected all zero",
               {d_busy, d_done, d_pre, d_wre, d_valid, d_last}, d_pix, d_w);
    end
    n_chk++;
    if ({s_busy, s_done, s_pre, s_wre, s_valid, s_last, s_neu, s_pa, s_wa} !== '0 ||
        s_pix !== '0 || s_w !== '0) begin
      n_fail++;
      $display("FAIL reset_sml: got ctl=%b pix=%h w=%h expected all zero",
               {s_busy, s_done, s_pre, s_wre, s_valid, s_last}, s_pix, s_w);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full default run; optionally pulses start while busy.
  task automatic test_full_run(input bit poke);
    grp_t e; rd_t r;
    logic [DPX-1:0] ep; logic [DWX-1:0] ew;
    int cyc, ngrp, nrd, ndone, last_acc;
    bit seen;
    q_grp.delete(); q_rd.delete();
    for (int n = 0; n < DNEU; n++)
      for (int g = 0; g < DNG; g++) begin
        ep = '0; ew = '0;
        for (int s = 0; s < DG; s++) begin
          int p;
          p = g*DG + s;
          if (p < DPN) begin
            ep[s*10 +: 10] = 10'(p);
            ew[s*19 +: 19] = 19'(n*DPN + p);
            r.pa = p; r.wa = n*DPN + p;
            q_rd.push_back(r);
          end
        end
        e.pix = ep; e.w = ew; e.last = (g == DNG-1); e.neu = 4'(n);
        q_grp.push_back(e);
      end
    d_start = 1'b1; @(negedge clk); d_start = 1'b0;
    cyc = 0; ngrp = 0; nrd = 0; ndone = 0; seen = 0; last_acc = -10;
    while (ndone == 0 && cyc < 12000) begin
      if (d_pre !== d_wre) begin
        n_chk++; n_fail++;
        $display("FAIL strobe_pair: pix_rd_en=%b w_rd_en=%b expected equal", d_pre, d_wre);
      end
      if (d_pre === 1'b1) begin
        n_chk++; nrd++;
        if (q_rd.size() == 0) begin
          n_fail++; $display("FAIL extra_read: got addr %0d expected no read", d_pa);
        end else begin
          r = q_rd.pop_front();
          if (d_pa !== 10'(r.pa) || d_wa !== 13'(r.wa)) begin
            n_fail++;
            $display("FAIL read_addr: got pa=%0d wa=%0d expected pa=%0d wa=%0d", d_pa, d_wa, r.pa, r.wa);
          end
        end
      end
      if (d_valid === 1'b1 && !seen) begin
        seen = 1;
        n_chk++;
        if (cyc != DG + 2) begin
          n_fail++; $display("FAIL latency: got %0d cycles expected %0d", cyc, DG + 2);
        end
        n_chk++;
        if (d_pix[0 +: 10] !== 10'd0 || d_pix[27*10 +: 10] !== 10'd27) begin
          n_fail++;
          $display("FAIL first_slots: got (0,0)=%0d (3,6)=%0d expected 0 and 27", d_pix[0 +: 10], d_pix[270 +: 10]);
        end
      end
      if (d_valid === 1'b1 && d_ready === 1'b1) begin
        ngrp++; last_acc = cyc;
        n_chk++;
        if (q_grp.size() == 0) begin
          n_fail++; $display("FAIL extra_group: got group %0d expected none", ngrp);
        end else begin
          e = q_grp.pop_front();
          if (d_pix !== e.pix) begin
            n_fail++; $display("FAIL grp_pix %0d: got %h expected %h", ngrp, d_pix, e.pix);
          end
          if (d_w !== e.w) begin
            n_fail++; $display("FAIL grp_w %0d: got %h expected %h", ngrp, d_w, e.w);
          end
          if (d_last !== e.last || d_neu !== e.neu) begin
            n_fail++;
            $display("FAIL grp_tag %0d: got last=%b neu=%0d expected last=%b neu=%0d", ngrp, d_last, d_neu, e.last, e.neu);
          end
        end
        if (ngrp == DNG) begin
          n_chk++;
          if (d_pix[0 +: 10] !== 10'd784 || d_pix[DPX-1:10] !== '0 || d_w[DWX-1:19] !== '0 || d_last !== 1'b1) begin
            n_fail++;
            $display("FAIL pad_group: got slot0=%0d last=%b expected 784 with 27 zero slots, last=1", d_pix[0 +: 10], d_last);
          end
        end
      end
      if (d_done === 1'b1) begin
        ndone++;
        n_chk++;
        if (ngrp != DNEU*DNG || q_grp.size() != 0 || q_rd.size() != 0 || nrd != DNEU*DPN) begin
          n_fail++;
          $display("FAIL group_count: got groups=%0d reads=%0d expected %0d groups %0d reads", ngrp, nrd, DNEU*DNG, DNEU*DPN);
        end
        n_chk++;
        if (cyc != last_acc + 1 || d_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL done_timing: got done at %0d busy=%b expected %0d busy=1", cyc, d_busy, last_acc + 1);
        end
      end
      d_start = (poke && (cyc == 400 || cyc == 401)) ? 1'b1 : 1'b0;
      @(negedge clk); cyc++;
    end
    d_start = 1'b0;
    n_chk++;
    if (ndone == 0) begin
      n_fail++; $display("FAIL run_timeout: got no done expected done within 12000 cycles");
    end
    n_chk++;
    if (d_done !== 1'b0 || d_busy !== 1'b0 || d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: got done=%b busy=%b valid=%b expected 0 0 0", d_done, d_busy, d_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int nd;
    d_start = 1'b1; @(negedge clk); d_start = 1'b0;
    repeat (10) @(negedge clk);
    n_chk++;
    if (d_pre !== 1'b1 || d_busy !== 1'b1) begin
      n_fail++; $display("FAIL midrun_pre: got rd_en=%b busy=%b expected 1 1", d_pre, d_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({d_busy, d_done, d_pre, d_wre, d_valid, d_last, d_neu, d_pa, d_wa} !== '0 ||
        d_pix !== '0 || d_w !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got ctl=%b pa=%0d wa=%0d expected all zero",
               {d_busy, d_done, d_pre, d_wre, d_valid, d_last}, d_pa, d_wa);
    end
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (d_done !== 1'b0) nd++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (d_done !== 1'b0 || d_busy !== 1'b0) nd++;
    end
    n_chk++;
    if (nd != 0) begin
      n_fail++; $display("FAIL abort_done: got %0d done/busy cycles expected 0", nd);
    end
  endtask

  // Small-parameter run; optionally stalls the output for 50 cycles.
  task automatic test_small(input bit stall);
    grp_t e; rd_t r;
    logic [DPX-1:0] ep; logic [DWX-1:0] ew;
    logic [SPX+SWX+4:0] snap;
    int cyc, ngrp, nrd, ndone, hold, nstall_rd;
    bit seen, prev_hold;
    q_grp.delete(); q_rd.delete();
    for (int n = 0; n < SNEU; n++)
      for (int g = 0; g < SNG; g++) begin
        ep = '0; ew = '0;
        for (int s = 0; s < SG; s++) begin
          int p;
          p = g*SG + s;
          ep[s*10 +: 10] = 10'(p);
          ew[s*19 +: 19] = 19'(n*SPN + p);
          r.pa = p; r.wa = n*SPN + p;
          q_rd.push_back(r);
        end
        e.pix = ep; e.w = ew; e.last = (g == SNG-1); e.neu = 4'(n);
        q_grp.push_back(e);
      end
    s_start = 1'b1; @(negedge clk); s_start = 1'b0;
    cyc = 0; ngrp = 0; nrd = 0; ndone = 0; hold = 0; nstall_rd = 0; seen = 0; prev_hold = 0; snap = '0;
    while (ndone == 0 && cyc < 2000) begin
      if (stall && s_valid === 1'b1 && !seen) hold = 50;
      if (s_valid === 1'b1) seen = 1;
      s_ready = (hold == 0);
      if (prev_hold) begin
        n_chk++;
        if (s_valid !== 1'b1 || {s_pix, s_w, s_last, s_neu} !== snap) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b pix=%h expected valid=1 pix=%h", s_valid, s_pix, snap[SWX+5 +: SPX]);
        end
      end
      prev_hold = (s_valid === 1'b1) && !s_ready;
      snap = {s_pix, s_w, s_last, s_neu};
      if (hold > 0) begin
        hold--;
        if (s_pre === 1'b1) nstall_rd++;
      end
      if (s_pre === 1'b1) begin
        n_chk++;
        if (q_rd.size() == 0) begin
          n_fail++; $display("FAIL s_extra_read: got addr %0d expected no read", s_pa);
        end else begin
          r = q_rd.pop_front();
          if (s_pa !== 10'(r.pa) || s_wa !== 13'(r.wa) || s_wre !== 1'b1) begin
            n_fail++;
            $display("FAIL s_read_addr: got pa=%0d wa=%0d expected pa=%0d wa=%0d", s_pa, s_wa, r.pa, r.wa);
          end
        end
        if (nrd == SPN) begin
          n_chk++;
          if (s_wa !== 13'd30) begin
            n_fail++; $display("FAIL n1_first_waddr: got %0d expected 30", s_wa);
          end
        end
        nrd++;
      end
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
        ngrp++;
        n_chk++;
        if (q_grp.size() == 0) begin
          n_fail++; $display("FAIL s_extra_group: got group %0d expected none", ngrp);
        end else begin
          e = q_grp.pop_front();
          if (s_pix !== e.pix[SPX-1:0] || s_w !== e.w[SWX-1:0] || s_last !== e.last || s_neu !== e.neu) begin
            n_fail++;
            $display("FAIL s_grp %0d: got pix=%h w=%h last=%b neu=%0d expected pix=%h w=%h last=%b neu=%0d",
                     ngrp, s_pix, s_w, s_last, s_neu, e.pix[SPX-1:0], e.w[SWX-1:0], e.last, e.neu);
          end
        end
      end
      if (s_done === 1'b1) ndone++;
      @(negedge clk); cyc++;
    end
    s_ready = 1'b1;
    n_chk++;
    if (ndone == 0 || ngrp != SNEU*SNG || nrd != SNEU*SPN || q_grp.size() != 0) begin
      n_fail++;
      $display("FAIL s_count: got done=%0d groups=%0d reads=%0d expected 1 %0d %0d", ndone, ngrp, nrd, SNEU*SNG, SNEU*SPN);
    end
    if (stall) begin
      n_chk++;
      if (nstall_rd != SG) begin
        n_fail++; $display("FAIL stall_reads: got %0d reads during stall expected %0d", nstall_rd, SG);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_run(1'b0);
    test_small(1'b0);
    test_small(1'b1);
    test_reset_mid_run();
    test_full_run(1'b0);
    test_full_run(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dp_feeder.md
DP_FEEDER -- requirements
Module: dp_feeder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NEURONS, 10, neurons per run
- PIXEL_N, 785, pixels per neuron (bias included)
- PIXEL_SIZE, 10, pixel word width
- WEIGHT_SIZE, 19, weight word width
- PARALLEL, 4, bus lanes
- BUS_WIDTH, 7, slots per lane
- PA_W, 10, pixel address width
- WA_W, 13, weight address width

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge
- GlobalReset_n, in, 1, reset, asynchronous, active-low
- start, in, 1, begin a run; sampled only in IDLE
- busy, out, 1, run in progress
- done, out, 1, one-cycle pulse at end of run
- pix_rd_en, out, 1, pixel RAM read strobe
- pix_addr, out, PA_W, pixel RAM address
- pix_rdata, in, PIXEL_SIZE, pixel data, valid 1 cycle after strobe
- w_rd_en, out, 1, weight RAM read strobe
- w_addr, out, WA_W, weight RAM address
- w_rdata, in, WEIGHT_SIZE, weight data, valid 1 cycle after strobe
- Pixels, out, BUS_WIDTH*PARALLEL*PIXEL_SIZE, packed pixel bus to dot-product unit
- Weights, out, BUS_WIDTH*PARALLEL*WEIGHT_SIZE, packed weight bus
- bus_valid, out, 1, Pixels/Weights hold a group
- bus_ready, in, 1, consumer accepts group
- bus_last, out, 1, group is the final one of its neuron
- bus_neuron, out, 4, neuron index of the presented group

Function
REQ-003 Group size G = PARALLEL*BUS_WIDTH. Groups per neuron NG = ceil(PIXEL_N/G); with defaults G=28 and NG=29.
REQ-004 Slot (lane j, position k) of group g carries pixel index p = g*G + j*BUS_WIDTH + k, packed at bit offset (j*BUS_WIDTH + k)*PIXEL_SIZE in Pixels and (j*BUS_WIDTH + k)*WEIGHT_SIZE in Weights.
REQ-005 Read addresses: pix_addr = p; w_addr = n*PIXEL_N + p for neuron n.
REQ-006 Padding: if p >= PIXEL_N, no read is issued and the slot is loaded with zero pixel and zero weight.
REQ-007 FSM has four states.
- IDLE: leaves to FETCH on start.
- FETCH: issues one slot per cycle, slot order k fastest, then j.
- WAIT: entered after the last slot of a group is issued; holds until the final data is captured and the staging register has transferred.
- DONE: one cycle, then returns to IDLE.
REQ-008 pix_rd_en and w_rd_en are asserted together, only in FETCH, only for non-padded slots.
REQ-009 Read data is captured into the staging register exactly one cycle after its strobe; a per-slot pipeline flag carries the pad indication.
REQ-010 Transfer from staging to output register occurs when staging is complete AND (bus_valid==0 OR bus_ready==1) in the same cycle; bus_valid is then high the following cycle.
REQ-011 The output register, bus_last and bus_neuron hold stable while bus_valid && !bus_ready. bus_valid falls after acceptance unless a new transfer happens in the same cycle.
REQ-012 The next group is fetched only after the previous staging transfer; output-side stall therefore stalls fetch.
REQ-013 Latency: with bus_ready held high, the first bus_valid occurs G+2 cycles after the edge that samples start.
REQ-014 After neuron NEURONS-1, group NG-1 is accepted: done pulses the next cycle and busy falls with it.
REQ-015 busy is high from the cycle after start is sampled through the done cycle.
REQ-016 start asserted while busy is ignored.

Reset
REQ-017 GlobalReset_n low asynchronously clears all state: FSM to IDLE; counters, staging and output registers to 0; all outputs to 0.
REQ-018 Reset mid-run aborts the run with no done pulse; read strobes drop immediately.

Verification
REQ-019 Defaults, bus_ready=1, RAM data = address low bits, start pulse: first bus_valid after 30 cycles; Pixels slot (0,0)=0 and slot (3,6)=27; exactly 290 groups; done after the last group.
REQ-020 Defaults, group 28 of neuron 0: only slot (0,0) is nonzero (p=784); 27 zero slots; exactly one read strobe issued for that group; bus_last=1.
REQ-021 PIXEL_N=30, PARALLEL=2, BUS_WIDTH=3, NEURONS=2: 10 groups; neuron 1 group 0 first w_addr=30; no padding occurs.
REQ-022 bus_ready held low for 50 cycles after the first bus_valid: output stable, read strobes stop after 6 more, no data lost; the remaining groups follow after release.
REQ-023 GlobalReset_n pulsed low mid-FETCH: all outputs 0 immediately, no done; a fresh start produces the full sequence from neuron 0.
REQ-024 start pulsed again while busy: no effect; group count unchanged.
